// File: rtl/jelly_address_burst_limit.sv
// Splits one long transfer command into bursts of at most MAX_LEN units, with first/last flags.
// Optional: JELLY_ADDRESS_BURST_LIMIT_ALIGN_FIRST_EN trims the first burst to a MAX_LEN unit boundary.
module jelly_address_burst_limit #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned UNIT_SIZE    = 3,
  parameter int unsigned S_LEN_WIDTH  = 16,
  parameter bit          S_LEN_OFFSET = 1'b1,
  parameter int unsigned M_LEN_WIDTH  = 8,
  parameter bit          M_LEN_OFFSET = 1'b1,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned USER_WIDTH   = 0,
  parameter bit          S_REGS       = 1'b1,
  localparam int unsigned USER_BITS   = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic                   cke,

  input  logic [ADDR_WIDTH-1:0]  s_addr,
  input  logic [S_LEN_WIDTH-1:0] s_len,
  input  logic [USER_BITS-1:0]   s_user,
  input  logic                   s_valid,
  output logic                   s_ready,

  output logic                   m_first,
  output logic                   m_last,
  output logic [ADDR_WIDTH-1:0]  m_addr,
  output logic [M_LEN_WIDTH-1:0] m_len,
  output logic [USER_BITS-1:0]   m_user,
  output logic                   m_valid,
  input  logic                   m_ready
);

  // Remaining-length arithmetic needs one extra bit for the offset-coded input.
  localparam int unsigned RW = S_LEN_WIDTH + 1;
  localparam logic [RW-1:0] MaxLen = RW'(MAX_LEN);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  logic [ADDR_WIDTH-1:0]  core_addr;
  logic [S_LEN_WIDTH-1:0] core_len;
  logic [USER_BITS-1:0]   core_user;
  logic                   core_valid;
  logic                   core_ready;

  // Input side: optional register slice in front of the core.
  if (S_REGS) begin : g_s_regs
    logic                   slice_valid_q;
    logic [ADDR_WIDTH-1:0]  slice_addr_q;
    logic [S_LEN_WIDTH-1:0] slice_len_q;
    logic [USER_BITS-1:0]   slice_user_q;

    assign s_ready = cke && (!slice_valid_q || core_ready);

    always_ff @(posedge clk) begin
      if (reset) begin
        slice_valid_q <= 1'b0;
      end else if (s_ready) begin
        slice_valid_q <= s_valid;
      end
    end

    always_ff @(posedge clk) begin
      if (s_ready) begin
        slice_addr_q <= s_addr;
        slice_len_q  <= s_len;
        slice_user_q <= s_user;
      end
    end

    assign core_addr  = slice_addr_q;
    assign core_len   = slice_len_q;
    assign core_user  = slice_user_q;
    assign core_valid = slice_valid_q;
  end else begin : g_s_direct
    assign s_ready    = core_ready;
    assign core_addr  = s_addr;
    assign core_len   = s_len;
    assign core_user  = s_user;
    assign core_valid = s_valid;
  end

  state_e                 state_q, state_d;
  logic [RW-1:0]          rem_q, rem_d;
  logic [ADDR_WIDTH-1:0]  next_addr_q, next_addr_d;
  logic [USER_BITS-1:0]   user_q, user_d;
  logic                   m_valid_q, m_valid_d;
  logic                   m_first_q, m_first_d;
  logic                   m_last_q, m_last_d;
  logic [ADDR_WIDTH-1:0]  m_addr_q, m_addr_d;
  logic [M_LEN_WIDTH-1:0] m_len_q, m_len_d;
  logic [USER_BITS-1:0]   m_user_q, m_user_d;

  logic                   advance;
  logic                   emit;
  logic                   first;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic [RW-1:0]          base_rem;
  logic [RW-1:0]          limit;
  logic [RW-1:0]          cnt;

`ifdef JELLY_ADDRESS_BURST_LIMIT_ALIGN_FIRST_EN
  logic [ADDR_WIDTH-1:0]  unit_addr;
  logic [ADDR_WIDTH-1:0]  unit_off;
  assign unit_addr = core_addr >> UNIT_SIZE;
  assign unit_off  = unit_addr & ADDR_WIDTH'(MAX_LEN - 1);
`endif

  assign advance    = cke && (!m_valid_q || m_ready);
  assign core_ready = advance && (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    next_addr_d = next_addr_q;
    user_d      = user_q;
    m_valid_d   = m_valid_q;
    m_first_d   = m_first_q;
    m_last_d    = m_last_q;
    m_addr_d    = m_addr_q;
    m_len_d     = m_len_q;
    m_user_d    = m_user_q;
    emit        = 1'b0;
    first       = 1'b0;
    base_addr   = next_addr_q;
    base_rem    = rem_q;
    limit       = MaxLen;

    if (advance) begin
      unique case (state_q)
        StIdle: begin
          m_valid_d = 1'b0;
          if (core_valid) begin
            base_addr = core_addr;
            base_rem  = RW'(core_len) + RW'(S_LEN_OFFSET);
            user_d    = core_user;
            first     = 1'b1;
            // A zero-length command is consumed without emitting anything.
            emit      = (base_rem != '0);
`ifdef JELLY_ADDRESS_BURST_LIMIT_ALIGN_FIRST_EN
            limit     = MaxLen - RW'(unit_off);
`endif
          end
        end
        StBusy: begin
          emit = 1'b1;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    cnt = (base_rem < limit) ? base_rem : limit;

    if (emit) begin
      m_valid_d   = 1'b1;
      m_first_d   = first;
      m_last_d    = (base_rem == cnt);
      m_addr_d    = base_addr;
      m_len_d     = M_LEN_WIDTH'(cnt - RW'(M_LEN_OFFSET));
      m_user_d    = user_d;
      next_addr_d = base_addr + (ADDR_WIDTH'(cnt) << UNIT_SIZE);
      rem_d       = base_rem - cnt;
      state_d     = (base_rem == cnt) ? StIdle : StBusy;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      m_valid_q <= 1'b0;
    end else if (cke) begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cke) begin
      rem_q       <= rem_d;
      next_addr_q <= next_addr_d;
      user_q      <= user_d;
      m_first_q   <= m_first_d;
      m_last_q    <= m_last_d;
      m_addr_q    <= m_addr_d;
      m_len_q     <= m_len_d;
      m_user_q    <= m_user_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_first = m_first_q;
  assign m_last  = m_last_q;
  assign m_addr  = m_addr_q;
  assign m_len   = m_len_q;
  assign m_user  = m_user_q;

endmodule

// File: tb/tb_jelly_address_burst_limit.sv
// Directed bench: instance a is 32-bit, direct input, 4-bit user; instance b is 16-bit, sliced input.
module tb_jelly_address_burst_limit;

  logic clk = 1'b0;
  logic reset;
  logic cke;

  always #5 clk = ~clk;

  logic [31:0] a_s_addr;
  logic [15:0] a_s_len;
  logic [3:0]  a_s_user;
  logic        a_s_valid;
  logic        a_s_ready;
  logic        a_m_first;
  logic        a_m_last;
  logic [31:0] a_m_addr;
  logic [7:0]  a_m_len;
  logic [3:0]  a_m_user;
  logic        a_m_valid;
  logic        a_m_ready;

  logic [15:0] b_s_addr;
  logic [15:0] b_s_len;
  logic [0:0]  b_s_user;
  logic        b_s_valid;
  logic        b_s_ready;
  logic        b_m_first;
  logic        b_m_last;
  logic [15:0] b_m_addr;
  logic [7:0]  b_m_len;
  logic [0:0]  b_m_user;
  logic        b_m_valid;
  logic        b_m_ready;

  jelly_address_burst_limit #(
    .ADDR_WIDTH  (32),
    .USER_WIDTH  (4),
    .S_REGS      (1'b0)
  ) u_dut_a (
    .reset   (reset),
    .clk     (clk),
    .cke     (cke),
    .s_addr  (a_s_addr),
    .s_len   (a_s_len),
    .s_user  (a_s_user),
    .s_valid (a_s_valid),
    .s_ready (a_s_ready),
    .m_first (a_m_first),
    .m_last  (a_m_last),
    .m_addr  (a_m_addr),
    .m_len   (a_m_len),
    .m_user  (a_m_user),
    .m_valid (a_m_valid),
    .m_ready (a_m_ready)
  );

  jelly_address_burst_limit #(
    .ADDR_WIDTH  (16),
    .USER_WIDTH  (0),
    .S_REGS      (1'b1)
  ) u_dut_b (
    .reset   (reset),
    .clk     (clk),
    .cke     (cke),
    .s_addr  (b_s_addr),
    .s_len   (b_s_len),
    .s_user  (b_s_user),
    .s_valid (b_s_valid),
    .s_ready (b_s_ready),
    .m_first (b_m_first),
    .m_last  (b_m_last),
    .m_addr  (b_m_addr),
    .m_len   (b_m_len),
    .m_user  (b_m_user),
    .m_valid (b_m_valid),
    .m_ready (b_m_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [31:0] addr, input logic [7:0] len,
                         input logic first, input logic last, input logic [3:0] user);
    check({tag, ".valid"}, 64'(a_m_valid), 64'(1'b1));
    check({tag, ".addr"},  64'(a_m_addr),  64'(addr));
    check({tag, ".len"},   64'(a_m_len),   64'(len));
    check({tag, ".first"}, 64'(a_m_first), 64'(first));
    check({tag, ".last"},  64'(a_m_last),  64'(last));
    check({tag, ".user"},  64'(a_m_user),  64'(user));
  endtask

  task automatic check_b(input string tag, input logic [15:0] addr, input logic [7:0] len,
                         input logic first, input logic last);
    check({tag, ".valid"}, 64'(b_m_valid), 64'(1'b1));
    check({tag, ".addr"},  64'(b_m_addr),  64'(addr));
    check({tag, ".len"},   64'(b_m_len),   64'(len));
    check({tag, ".first"}, 64'(b_m_first), 64'(first));
    check({tag, ".last"},  64'(b_m_last),  64'(last));
  endtask

  task automatic cmd_a(input logic [31:0] addr, input logic [15:0] len, input logic [3:0] user);
    a_s_addr  = addr;
    a_s_len   = len;
    a_s_user  = user;
    a_s_valid = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    cke       = 1'b1;
    a_s_addr  = '0;
    a_s_len   = '0;
    a_s_user  = '0;
    a_s_valid = 1'b0;
    a_m_ready = 1'b1;
    b_s_addr  = '0;
    b_s_len   = '0;
    b_s_user  = '0;
    b_s_valid = 1'b0;
    b_m_ready = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    #1;
    check("rst.a_valid", 64'(a_m_valid), 64'(1'b0));
    check("rst.b_valid", 64'(b_m_valid), 64'(1'b0));
    check("rst.a_ready", 64'(a_s_ready), 64'(1'b1));

    // Three bursts back-to-back, ready returns after the last one.
    cmd_a(32'h1000, 16'd39, 4'h5);
    #1 check("t1.ready", 64'(a_s_ready), 64'(1'b1));
    tick; a_s_valid = 1'b0;
    #1 check_a("t1.b0", 32'h1000, 8'd15, 1'b1, 1'b0, 4'h5);
    check("t1.busy_ready", 64'(a_s_ready), 64'(1'b0));
    tick; #1 check_a("t1.b1", 32'h1080, 8'd15, 1'b0, 1'b0, 4'h5);
    tick; #1 check_a("t1.b2", 32'h1100, 8'd7, 1'b0, 1'b1, 4'h5);
    check("t1.ready_after", 64'(a_s_ready), 64'(1'b1));
    tick; #1 check("t1.idle", 64'(a_m_valid), 64'(1'b0));

    // Single bursts, including zero-coded length, with no gap between commands.
    cmd_a(32'h3000, 16'd15, 4'hA);
    #1 check("t2.ready", 64'(a_s_ready), 64'(1'b1));
    tick; cmd_a(32'h4000, 16'd0, 4'hB);
    #1 check_a("t2.a", 32'h3000, 8'd15, 1'b1, 1'b1, 4'hA);
    check("t2.ready_b2b", 64'(a_s_ready), 64'(1'b1));
    tick; a_s_valid = 1'b0;
    #1 check_a("t2.b", 32'h4000, 8'd0, 1'b1, 1'b1, 4'hB);
    tick; #1 check("t2.idle", 64'(a_m_valid), 64'(1'b0));

    // Back-pressure and clock-enable stall while burst 2 is presented.
    cmd_a(32'h1000, 16'd39, 4'h3);
    tick; a_s_valid = 1'b0;
    #1 check_a("t3.b0", 32'h1000, 8'd15, 1'b1, 1'b0, 4'h3);
    tick; a_m_ready = 1'b0;
    #1 check_a("t3.b1", 32'h1080, 8'd15, 1'b0, 1'b0, 4'h3);
    for (int i = 0; i < 3; i++) begin
      tick;
      #1 check_a("t3.hold", 32'h1080, 8'd15, 1'b0, 1'b0, 4'h3);
      check("t3.hold_ready", 64'(a_s_ready), 64'(1'b0));
    end
    cke = 1'b0; a_m_ready = 1'b1;
    tick; #1 check_a("t3.cke", 32'h1080, 8'd15, 1'b0, 1'b0, 4'h3);
    cke = 1'b1;
    tick; #1 check_a("t3.b2", 32'h1100, 8'd7, 1'b0, 1'b1, 4'h3);
    tick; #1 check("t3.idle", 64'(a_m_valid), 64'(1'b0));

    // Reset mid-transfer discards the rest of the command.
    cmd_a(32'h1000, 16'd39, 4'h1);
    tick; a_s_valid = 1'b0;
    #1 check_a("t4.b0", 32'h1000, 8'd15, 1'b1, 1'b0, 4'h1);
    tick; #1 check_a("t4.b1", 32'h1080, 8'd15, 1'b0, 1'b0, 4'h1);
    reset = 1'b1;
    tick; reset = 1'b0;
    #1 check("t4.rst_valid", 64'(a_m_valid), 64'(1'b0));
    cmd_a(32'h2000, 16'd3, 4'h2);
    #1 check("t4.ready", 64'(a_s_ready), 64'(1'b1));
    tick; a_s_valid = 1'b0;
    #1 check_a("t4.new", 32'h2000, 8'd3, 1'b1, 1'b1, 4'h2);
    tick; #1 check("t4.idle", 64'(a_m_valid), 64'(1'b0));

    // 16-bit address wrap through the sliced instance.
    b_s_addr  = 16'hFFC0;
    b_s_len   = 16'd31;
    b_s_valid = 1'b1;
    #1 check("t5.ready", 64'(b_s_ready), 64'(1'b1));
    tick; b_s_valid = 1'b0;
    #1 check("t5.slice_lat", 64'(b_m_valid), 64'(1'b0));
`ifdef JELLY_ADDRESS_BURST_LIMIT_ALIGN_FIRST_EN
    tick; #1 check_b("t5.b0", 16'hFFC0, 8'd7, 1'b1, 1'b0);
    tick; #1 check_b("t5.b1", 16'h0000, 8'd15, 1'b0, 1'b0);
    tick; #1 check_b("t5.b2", 16'h0080, 8'd7, 1'b0, 1'b1);
`else
    tick; #1 check_b("t5.b0", 16'hFFC0, 8'd15, 1'b1, 1'b0);
    tick; #1 check_b("t5.b1", 16'h0040, 8'd15, 1'b0, 1'b1);
`endif
    tick; #1 check("t5.idle", 64'(b_m_valid), 64'(1'b0));

    // Unaligned start address.
    cmd_a(32'h1038, 16'd39, 4'h7);
    tick; a_s_valid = 1'b0;
`ifdef JELLY_ADDRESS_BURST_LIMIT_ALIGN_FIRST_EN
    #1 check_a("t6.b0", 32'h1038, 8'd8, 1'b1, 1'b0, 4'h7);
    tick; #1 check_a("t6.b1", 32'h1080, 8'd15, 1'b0, 1'b0, 4'h7);
    tick; #1 check_a("t6.b2", 32'h1100, 8'd14, 1'b0, 1'b1, 4'h7);
`else
    #1 check_a("t6.b0", 32'h1038, 8'd15, 1'b1, 1'b0, 4'h7);
    tick; #1 check_a("t6.b1", 32'h10B8, 8'd15, 1'b0, 1'b0, 4'h7);
    tick; #1 check_a("t6.b2", 32'h1138, 8'd7, 1'b0, 1'b1, 4'h7);
`endif
    tick; #1 check("t6.idle", 64'(a_m_valid), 64'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
